// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register for the 5-stage ARM core: one-cycle latency, flush > freeze > hazard > load.
// Backpressure: freeze holds every field and the bubble counter; flush always wins, even during a stall.
module id_exe_reg #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             freeze,
    input  logic             hazard,
    input  logic             cond_ok,
    input  logic [3:0]       exe_cmd_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             wb_en_in,
    input  logic             branch_in,
    input  logic             s_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PC_W-1:0]  val_rn_in,
    input  logic [PC_W-1:0]  val_rm_in,
    input  logic             imm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm_24_in,
    input  logic [3:0]       dest_in,
    input  logic [3:0]       src1_in,
    input  logic [3:0]       src2_in,
    input  logic             carry_in,
    output logic [3:0]       exe_cmd_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             wb_en_out,
    output logic             branch_out,
    output logic             s_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  val_rn_out,
    output logic [PC_W-1:0]  val_rm_out,
    output logic             imm_out,
    output logic [11:0]      shift_operand_out,
    output logic [23:0]      signed_imm_24_out,
    output logic [3:0]       dest_out,
    output logic [3:0]       src1_out,
    output logic [3:0]       src2_out,
    output logic             carry_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [3:0]       r_exe_cmd;
    logic             r_mem_read, r_mem_write, r_wb_en, r_branch, r_s, r_valid;
    logic [PC_W-1:0]  r_pc, r_val_rn, r_val_rm;
    logic             r_imm, r_carry;
    logic [11:0]      r_shift_operand;
    logic [23:0]      r_signed_imm_24;
    logic [3:0]       r_dest, r_src1, r_src2;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_hold;
    logic w_load_data;
    logic w_load_ctrl;
    logic w_bubble;

    // Every non-held cycle that does not load a real instruction writes valid=0 and counts as a bubble.
    always_comb begin
        w_hold      = 1'b0;
        w_load_data = 1'b0;
        w_load_ctrl = 1'b0;
        w_bubble    = 1'b0;
        if (!flush && freeze) begin
            w_hold = 1'b1;
        end else if (!flush) begin
            w_load_data = 1'b1;
            w_load_ctrl = !hazard && cond_ok;
        end
        w_bubble = !w_hold && !w_load_ctrl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe_cmd   <= 4'b0000;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_en     <= 1'b0;
            r_branch    <= 1'b0;
            r_s         <= 1'b0;
            r_valid     <= 1'b0;
        end else if (w_load_ctrl) begin
            r_exe_cmd   <= exe_cmd_in;
            r_mem_read  <= mem_read_in;
            r_mem_write <= mem_write_in;
            r_wb_en     <= wb_en_in;
            r_branch    <= branch_in;
            r_s         <= s_in;
            r_valid     <= 1'b1;
        end else if (!w_hold) begin
            r_exe_cmd   <= 4'b0000;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_en     <= 1'b0;
            r_branch    <= 1'b0;
            r_s         <= 1'b0;
            r_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
            r_carry         <= 1'b0;
        end else if (w_load_data) begin
            r_pc            <= pc_in;
            r_val_rn        <= val_rn_in;
            r_val_rm        <= val_rm_in;
            r_imm           <= imm_in;
            r_shift_operand <= shift_operand_in;
            r_signed_imm_24 <= signed_imm_24_in;
            r_dest          <= dest_in;
            r_src1          <= src1_in;
            r_src2          <= src2_in;
            r_carry         <= carry_in;
        end
    end

    // Saturating: stays at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign exe_cmd_out       = r_exe_cmd;
    assign mem_read_out      = r_mem_read;
    assign mem_write_out     = r_mem_write;
    assign wb_en_out         = r_wb_en;
    assign branch_out        = r_branch;
    assign s_out             = r_s;
    assign valid_out         = r_valid;
    assign pc_out            = r_pc;
    assign val_rn_out        = r_val_rn;
    assign val_rm_out        = r_val_rm;
    assign imm_out           = r_imm;
    assign shift_operand_out = r_shift_operand;
    assign signed_imm_24_out = r_signed_imm_24;
    assign dest_out          = r_dest;
    assign src1_out          = r_src1;
    assign src2_out          = r_src2;
    assign carry_out         = r_carry;
    assign bubble_cnt        = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: scoreboard of expected register contents plus directed field checks.
module tb_id_exe_reg;

    typedef logic [163:0] vec_t;

    typedef struct packed {
        logic [3:0]  exe_cmd;
        logic        mem_read, mem_write, wb_en, branch, s;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2;
        logic        carry;
        logic        valid;
        logic [7:0]  cnt;
    } out_t;

    typedef struct packed {
        logic        flush, freeze, hazard, cond_ok;
        logic [3:0]  exe_cmd;
        logic        mem_read, mem_write, wb_en, branch, s;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2;
        logic        carry;
    } in_t;

    logic        clk;
    logic        rst_n;
    in_t         stim;
    out_t        obs;
    out_t        exp_s;
    out_t        sb_q[$];
    int          n_chk;
    int          n_pass;
    logic [7:0]  c0;

    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
    logic        mem_read_out, mem_write_out, wb_en_out, branch_out, s_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out, carry_out, valid_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [7:0]  bubble_cnt;

    id_exe_reg #(.PC_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .flush(stim.flush), .freeze(stim.freeze), .hazard(stim.hazard), .cond_ok(stim.cond_ok),
        .exe_cmd_in(stim.exe_cmd), .mem_read_in(stim.mem_read), .mem_write_in(stim.mem_write),
        .wb_en_in(stim.wb_en), .branch_in(stim.branch), .s_in(stim.s),
        .pc_in(stim.pc), .val_rn_in(stim.rn), .val_rm_in(stim.rm),
        .imm_in(stim.imm), .shift_operand_in(stim.shift), .signed_imm_24_in(stim.simm),
        .dest_in(stim.dest), .src1_in(stim.src1), .src2_in(stim.src2), .carry_in(stim.carry),
        .exe_cmd_out(exe_cmd_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .wb_en_out(wb_en_out), .branch_out(branch_out), .s_out(s_out),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
        .valid_out(valid_out), .bubble_cnt(bubble_cnt)
    );

    assign obs = {exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, branch_out, s_out,
                  pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm_24_out,
                  dest_out, src1_out, src2_out, carry_out, valid_out, bubble_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic out_t model(input out_t c, input in_t i);
        out_t n;
        logic bub;
        n   = c;
        bub = 1'b0;
        if (i.flush) begin
            n   = '0;
            bub = 1'b1;
        end else if (!i.freeze) begin
            n.pc = i.pc; n.rn = i.rn; n.rm = i.rm; n.imm = i.imm;
            n.shift = i.shift; n.simm = i.simm; n.dest = i.dest;
            n.src1 = i.src1; n.src2 = i.src2; n.carry = i.carry;
            if (i.hazard || !i.cond_ok) begin
                n.exe_cmd = 4'd0; n.mem_read = 1'b0; n.mem_write = 1'b0;
                n.wb_en = 1'b0; n.branch = 1'b0; n.s = 1'b0; n.valid = 1'b0;
                bub = 1'b1;
            end else begin
                n.exe_cmd = i.exe_cmd; n.mem_read = i.mem_read; n.mem_write = i.mem_write;
                n.wb_en = i.wb_en; n.branch = i.branch; n.s = i.s; n.valid = 1'b1;
            end
        end
        n.cnt = (bub && c.cnt != 8'hFF) ? c.cnt + 8'd1 : c.cnt;
        return n;
    endfunction

    function automatic in_t rnd_data();
        in_t s;
        s         = '0;
        s.exe_cmd = 4'($urandom);
        s.mem_read = 1'($urandom); s.mem_write = 1'($urandom); s.wb_en = 1'($urandom);
        s.branch  = 1'($urandom); s.s = 1'($urandom);
        s.pc = $urandom; s.rn = $urandom; s.rm = $urandom;
        s.imm = 1'($urandom); s.shift = 12'($urandom); s.simm = 24'($urandom);
        s.dest = 4'($urandom); s.src1 = 4'($urandom); s.src2 = 4'($urandom);
        s.carry = 1'($urandom);
        return s;
    endfunction

    // Push the expected result at drive time, pop it one edge later.
    task automatic cycle();
        out_t e;
        exp_s = model(exp_s, stim);
        sb_q.push_back(exp_s);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("scoreboard", vec_t'(obs), vec_t'(e));
    endtask

    // Asserted between edges with nonzero inputs; outputs must clear without a clock.
    task automatic mid_reset();
        stim = rnd_data();
        stim.cond_ok = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("reset_async", vec_t'(obs), vec_t'(0));
        exp_s = '0;
        @(posedge clk);
        #1 chk("reset_held", vec_t'(obs), vec_t'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        stim   = '0;
        exp_s  = '0;
        rst_n  = 1'b0;
        #2 chk("reset_initial", vec_t'(obs), vec_t'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            stim = rnd_data();
            stim.cond_ok = 1'b1;
            cycle();
        end
        mid_reset();

        stim = '0;
        stim.cond_ok = 1'b1; stim.exe_cmd = 4'b0010; stim.wb_en = 1'b1; stim.pc = 32'h14;
        cycle();
        chk("rel_exe_cmd", vec_t'(exe_cmd_out), vec_t'(4'b0010));
        chk("rel_wb_en", vec_t'(wb_en_out), vec_t'(1'b1));
        chk("rel_pc", vec_t'(pc_out), vec_t'(32'h14));
        chk("rel_valid", vec_t'(valid_out), vec_t'(1'b1));

        stim = rnd_data();
        stim.cond_ok = 1'b1; stim.exe_cmd = 4'b0010; stim.dest = 4'd3;
        cycle();
        c0 = exp_s.cnt;
        for (int k = 0; k < 3; k++) begin
            stim = rnd_data();
            stim.cond_ok = 1'b1; stim.freeze = 1'b1; stim.exe_cmd = 4'b0100; stim.dest = 4'd5;
            cycle();
            chk("frz_exe_cmd", vec_t'(exe_cmd_out), vec_t'(4'b0010));
            chk("frz_dest", vec_t'(dest_out), vec_t'(4'd3));
            chk("frz_cnt", vec_t'(bubble_cnt), vec_t'(c0));
        end
        stim.freeze = 1'b0;
        cycle();
        chk("unfrz_exe_cmd", vec_t'(exe_cmd_out), vec_t'(4'b0100));
        chk("unfrz_dest", vec_t'(dest_out), vec_t'(4'd5));

        c0 = exp_s.cnt;
        stim = rnd_data();
        stim.cond_ok = 1'b1; stim.hazard = 1'b1;
        stim.mem_read = 1'b1; stim.wb_en = 1'b1; stim.rn = 32'h100;
        cycle();
        chk("haz_mem_read", vec_t'(mem_read_out), vec_t'(1'b0));
        chk("haz_wb_en", vec_t'(wb_en_out), vec_t'(1'b0));
        chk("haz_valid", vec_t'(valid_out), vec_t'(1'b0));
        chk("haz_rn", vec_t'(val_rn_out), vec_t'(32'h100));
        chk("haz_cnt", vec_t'(bubble_cnt), vec_t'(8'(c0 + 8'd1)));

        c0 = exp_s.cnt;
        stim = rnd_data();
        stim.flush = 1'b1; stim.freeze = 1'b1; stim.hazard = 1'b1; stim.cond_ok = 1'b1;
        stim.mem_write = 1'b1; stim.exe_cmd = 4'b0010;
        cycle();
        chk("fl_fields", vec_t'(obs[163:8]), vec_t'(0));
        chk("fl_cnt", vec_t'(bubble_cnt), vec_t'(8'(c0 + 8'd1)));

        c0 = exp_s.cnt;
        stim = rnd_data();
        stim.cond_ok = 1'b0; stim.branch = 1'b1; stim.simm = 24'hFFFFFE;
        cycle();
        chk("cf_branch", vec_t'(branch_out), vec_t'(1'b0));
        chk("cf_valid", vec_t'(valid_out), vec_t'(1'b0));
        chk("cf_simm", vec_t'(signed_imm_24_out), vec_t'(24'hFFFFFE));
        chk("cf_cnt", vec_t'(bubble_cnt), vec_t'(8'(c0 + 8'd1)));

        for (int k = 0; k < 300; k++) begin
            stim = rnd_data();
            stim.flush   = ($urandom_range(0, 9) == 0);
            stim.freeze  = ($urandom_range(0, 3) == 0);
            stim.hazard  = ($urandom_range(0, 4) == 0);
            stim.cond_ok = ($urandom_range(0, 4) != 0);
            cycle();
        end

        mid_reset();
        for (int k = 0; k < 260; k++) begin
            stim = rnd_data();
            stim.cond_ok = 1'b1; stim.hazard = 1'b1;
            cycle();
            chk("sat_cnt", vec_t'(bubble_cnt), vec_t'((k >= 254) ? 8'hFF : 8'(k + 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
